// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: line address width, L1 source IDs and arbiter states.
package cache_pkg;

  localparam int LINE_ADDR_W = 26;

  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L1 request strobes and the L2 valid/ready/done port, bundled for the arbiter.
interface l2_port_arbiter_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = LINE_ADDR_W
);

  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              dc_req_valid;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_req_wr;

  logic              l2_valid;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_wr;
  logic              l2_src;
  logic              l2_ready;
  logic              l2_done;

  // The arbiter is the master of the L2 port and the sink of the L1 strobes.
  modport master (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_addr, dc_req_wr,
    input  l2_ready, l2_done,
    output l2_valid, l2_addr, l2_wr, l2_src
  );

  modport slave (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_addr, dc_req_wr,
    output l2_ready, l2_done,
    input  l2_valid, l2_addr, l2_wr, l2_src
  );

endinterface

// File: rtl/l2_port_arbiter_req_fifo.sv
// Small first-word-fall-through request FIFO; the head entry is always visible on dout.
module req_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 request port between the L1 icache and dcache,
// with per-source grant and overflow-drop statistics.
module l2_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W     = LINE_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stats_clr,
  l2_port_arbiter_if.master bus,
  output logic [CNT_W-1:0]  ic_grant_cnt,
  output logic [CNT_W-1:0]  dc_grant_cnt,
  output logic [CNT_W-1:0]  ic_drop_cnt,
  output logic [CNT_W-1:0]  dc_drop_cnt
);

  arb_state_t state, state_next;
  logic       rr_last;

  logic              ic_full, ic_empty, ic_push, ic_pop, ic_drop;
  logic              dc_full, dc_empty, dc_push, dc_pop, dc_drop;
  logic [ADDR_W-1:0] ic_head;
  logic [ADDR_W:0]   dc_head;
  logic              accepted;

  logic              l2_valid_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic              l2_wr_q;
  logic              l2_src_q;

  // Fullness is judged before the pop, so a full FIFO popped this cycle still takes the push.
  assign ic_push = bus.ic_req_valid && (!ic_full || ic_pop);
  assign dc_push = bus.dc_req_valid && (!dc_full || dc_pop);
  assign ic_drop = bus.ic_req_valid && ic_full && !ic_pop;
  assign dc_drop = bus.dc_req_valid && dc_full && !dc_pop;

  req_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ic_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ic_push),
    .pop   (ic_pop),
    .din   (bus.ic_req_addr),
    .dout  (ic_head),
    .full  (ic_full),
    .empty (ic_empty)
  );

  req_fifo #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_dc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dc_push),
    .pop   (dc_pop),
    .din   ({bus.dc_req_wr, bus.dc_req_addr}),
    .dout  (dc_head),
    .full  (dc_full),
    .empty (dc_empty)
  );

  always_comb begin
    state_next = state;
    ic_pop     = 1'b0;
    dc_pop     = 1'b0;
    accepted   = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the source that did not win last time is served.
        if (!ic_empty && (dc_empty || rr_last == SRC_DC)) begin
          ic_pop     = 1'b1;
          state_next = ISSUE;
        end else if (!dc_empty) begin
          dc_pop     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.l2_ready) begin
          accepted   = 1'b1;
          state_next = bus.l2_done ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.l2_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_last    <= SRC_IC;
      l2_valid_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wr_q    <= 1'b0;
      l2_src_q   <= SRC_IC;
    end else begin
      state      <= state_next;
      l2_valid_q <= (state_next == ISSUE);
      if (ic_pop) begin
        l2_addr_q <= ic_head;
        l2_wr_q   <= 1'b0;
        l2_src_q  <= SRC_IC;
        rr_last   <= SRC_IC;
      end else if (dc_pop) begin
        l2_addr_q <= dc_head[ADDR_W-1:0];
        l2_wr_q   <= dc_head[ADDR_W];
        l2_src_q  <= SRC_DC;
        rr_last   <= SRC_DC;
      end
    end
  end

  // A clear wins over any increment landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      ic_grant_cnt <= '0;
      dc_grant_cnt <= '0;
      ic_drop_cnt  <= '0;
      dc_drop_cnt  <= '0;
    end else begin
      if (accepted && l2_src_q == SRC_IC) ic_grant_cnt <= ic_grant_cnt + 1'b1;
      if (accepted && l2_src_q == SRC_DC) dc_grant_cnt <= dc_grant_cnt + 1'b1;
      if (ic_drop) ic_drop_cnt <= ic_drop_cnt + 1'b1;
      if (dc_drop) dc_drop_cnt <= dc_drop_cnt + 1'b1;
    end
  end

  assign bus.l2_valid = l2_valid_q;
  assign bus.l2_addr  = l2_addr_q;
  assign bus.l2_wr    = l2_wr_q;
  assign bus.l2_src   = l2_src_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed-vector bench for l2_port_arbiter: each step drives one cycle of inputs and
// compares the registered outputs against hand-computed values.
module tb_l2_port_arbiter;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stats_clr;
  logic [31:0] ic_grant_cnt, dc_grant_cnt, ic_drop_cnt, dc_drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  l2_port_arbiter_if bus ();

  l2_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stats_clr    (stats_clr),
    .bus          (bus),
    .ic_grant_cnt (ic_grant_cnt),
    .dc_grant_cnt (dc_grant_cnt),
    .ic_drop_cnt  (ic_drop_cnt),
    .dc_drop_cnt  (dc_drop_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step just past the rising edge that samples them.
  task automatic applyStimulus(input logic icv, input logic [25:0] ica,
                               input logic dcv, input logic [25:0] dca, input logic dcw,
                               input logic rdy, input logic dn);
    bus.ic_req_valid = icv;
    bus.ic_req_addr  = ica;
    bus.dc_req_valid = dcv;
    bus.dc_req_addr  = dca;
    bus.dc_req_wr    = dcw;
    bus.l2_ready     = rdy;
    bus.l2_done      = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle(input logic rdy, input logic dn);
    applyStimulus(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, rdy, dn);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkL2(input string tag, input logic v, input logic [25:0] a,
                         input logic w, input logic s);
    checkOutput({tag, ".valid"}, 32'(bus.l2_valid), 32'(v));
    checkOutput({tag, ".addr"},  32'(bus.l2_addr),  32'(a));
    checkOutput({tag, ".wr"},    32'(bus.l2_wr),    32'(w));
    checkOutput({tag, ".src"},   32'(bus.l2_src),   32'(s));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyIdle(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [25:0] a;
    rst_n     = 1'b0;
    stats_clr = 1'b0;
    applyIdle(1'b0, 1'b0);
    applyIdle(1'b0, 1'b0);
    checkL2("reset", 1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("reset.ic_grant", ic_grant_cnt, 32'd0);
    checkOutput("reset.dc_grant", dc_grant_cnt, 32'd0);
    checkOutput("reset.ic_drop",  ic_drop_cnt,  32'd0);
    checkOutput("reset.dc_drop",  dc_drop_cnt,  32'd0);
    rst_n = 1'b1;

    // Single icache miss: two cycles from request to valid.
    applyStimulus(1'b1, 26'h0000ABC, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("miss.t0_valid", 32'(bus.l2_valid), 32'd0);
    applyIdle(1'b0, 1'b0);
    checkL2("miss.issue", 1'b1, 26'h0000ABC, 1'b0, SRC_IC);
    applyIdle(1'b1, 1'b0);
    checkOutput("miss.wait_valid", 32'(bus.l2_valid), 32'd0);
    checkOutput("miss.ic_grant", ic_grant_cnt, 32'd1);
    applyIdle(1'b0, 1'b0);
    applyIdle(1'b0, 1'b1);
    applyIdle(1'b0, 1'b0);
    checkOutput("miss.idle_valid", 32'(bus.l2_valid), 32'd0);
    checkOutput("miss.ic_grant_final", ic_grant_cnt, 32'd1);

    // Tie after reset: dcache first, then round-robin alternation.
    doReset();
    applyStimulus(1'b1, 26'h111, 1'b1, 26'h222, 1'b1, 1'b0, 1'b0);
    applyIdle(1'b0, 1'b0);
    checkL2("tie.first", 1'b1, 26'h222, 1'b1, SRC_DC);
    applyIdle(1'b1, 1'b0);
    checkOutput("tie.first_wait", 32'(bus.l2_valid), 32'd0);
    checkOutput("tie.dc_grant1", dc_grant_cnt, 32'd1);
    applyIdle(1'b0, 1'b1);
    applyIdle(1'b0, 1'b0);
    checkL2("tie.second", 1'b1, 26'h111, 1'b0, SRC_IC);
    applyIdle(1'b1, 1'b1);
    checkOutput("tie.ic_grant1", ic_grant_cnt, 32'd1);
    applyStimulus(1'b1, 26'h333, 1'b1, 26'h444, 1'b0, 1'b0, 1'b0);
    applyIdle(1'b0, 1'b0);
    checkL2("tie.rr_dc", 1'b1, 26'h444, 1'b0, SRC_DC);
    applyStimulus(1'b0, 26'h0, 1'b1, 26'h555, 1'b1, 1'b1, 1'b1);
    checkOutput("tie.ready_done_valid", 32'(bus.l2_valid), 32'd0);
    applyIdle(1'b1, 1'b1);
    checkL2("tie.rr_ic", 1'b1, 26'h333, 1'b0, SRC_IC);
    applyIdle(1'b1, 1'b1);
    checkOutput("tie.gap_valid", 32'(bus.l2_valid), 32'd0);
    applyIdle(1'b1, 1'b1);
    checkL2("tie.back_to_back", 1'b1, 26'h555, 1'b1, SRC_DC);
    applyIdle(1'b1, 1'b1);
    checkOutput("tie.ic_grant2", ic_grant_cnt, 32'd2);
    checkOutput("tie.dc_grant3", dc_grant_cnt, 32'd3);

    // Overflow: L2 stalled on an icache transaction while six dcache requests arrive.
    doReset();
    applyStimulus(1'b1, 26'h77, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = 26'h10 + 26'(i);
      applyStimulus(1'b0, 26'h0, 1'b1, a, i[0], 1'b0, 1'b0);
    end
    checkL2("ovf.hold", 1'b1, 26'h77, 1'b0, SRC_IC);
    checkOutput("ovf.dc_drop", dc_drop_cnt, 32'd2);
    checkOutput("ovf.ic_drop", ic_drop_cnt, 32'd0);
    applyIdle(1'b1, 1'b1);
    checkOutput("ovf.ic_grant", ic_grant_cnt, 32'd1);
    for (int k = 0; k < 4; k++) begin
      a = 26'h10 + 26'(k);
      applyIdle(1'b1, 1'b1);
      checkL2($sformatf("ovf.grant%0d", k), 1'b1, a, k[0], SRC_DC);
      applyIdle(1'b1, 1'b1);
      checkOutput($sformatf("ovf.gap%0d", k), 32'(bus.l2_valid), 32'd0);
    end
    checkOutput("ovf.dc_grant", dc_grant_cnt, 32'd4);
    checkOutput("ovf.dc_drop_final", dc_drop_cnt, 32'd2);
    stats_clr = 1'b1;
    applyIdle(1'b0, 1'b0);
    stats_clr = 1'b0;
    checkOutput("clr.ic_grant", ic_grant_cnt, 32'd0);
    checkOutput("clr.dc_grant", dc_grant_cnt, 32'd0);
    checkOutput("clr.dc_drop",  dc_drop_cnt,  32'd0);

    // Full with pop: a push into a full FIFO on the cycle it is popped is kept.
    doReset();
    applyStimulus(1'b1, 26'h77, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 26'h20 + 26'(i);
      applyStimulus(1'b0, 26'h0, 1'b1, a, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("fwp.fill_drop", dc_drop_cnt, 32'd0);
    applyIdle(1'b1, 1'b1);
    applyStimulus(1'b0, 26'h0, 1'b1, 26'h24, 1'b0, 1'b1, 1'b1);
    checkL2("fwp.first", 1'b1, 26'h20, 1'b0, SRC_DC);
    checkOutput("fwp.no_drop", dc_drop_cnt, 32'd0);
    applyIdle(1'b1, 1'b1);
    for (int k = 1; k < 5; k++) begin
      a = 26'h20 + 26'(k);
      applyIdle(1'b1, 1'b1);
      checkL2($sformatf("fwp.grant%0d", k), 1'b1, a, 1'b0, SRC_DC);
      applyIdle(1'b1, 1'b1);
    end
    checkOutput("fwp.dc_grant", dc_grant_cnt, 32'd5);
    checkOutput("fwp.dc_drop_final", dc_drop_cnt, 32'd0);

    // Reset while in WAIT with three icache entries queued, followed by a late done.
    doReset();
    applyStimulus(1'b1, 26'h30, 1'b1, 26'h40, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 26'h31, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    checkL2("rst.pre_issue", 1'b1, 26'h40, 1'b0, SRC_DC);
    applyStimulus(1'b1, 26'h32, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst.pre_wait", 32'(bus.l2_valid), 32'd0);
    checkOutput("rst.pre_dc_grant", dc_grant_cnt, 32'd1);
    doReset();
    checkL2("rst.after", 1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("rst.dc_grant", dc_grant_cnt, 32'd0);
    applyIdle(1'b0, 1'b1);
    checkOutput("rst.late_done", 32'(bus.l2_valid), 32'd0);
    applyIdle(1'b0, 1'b0);
    checkOutput("rst.fifo_empty", 32'(bus.l2_valid), 32'd0);
    applyStimulus(1'b1, 26'h50, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    applyIdle(1'b0, 1'b0);
    checkL2("rst.fresh", 1'b1, 26'h50, 1'b0, SRC_IC);

    // A clear in the same cycle as an accept leaves the counter at zero.
    stats_clr = 1'b1;
    applyIdle(1'b1, 1'b0);
    stats_clr = 1'b0;
    checkOutput("clr.priority", ic_grant_cnt, 32'd0);
    applyIdle(1'b0, 1'b1);
    checkOutput("clr.fsm_idle", 32'(bus.l2_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
